// File: rtl/data_mem_responder.sv
// Slow data-memory responder for the CPU mRD/mWR port: byte-addressed big-endian RAM
// answering word requests after WAIT_CYCLES wait states with a one-cycle ready strobe.
module data_mem_responder #(
  parameter int          DEPTH         = 128,
  parameter int          WAIT_CYCLES   = 2,
  parameter logic [15:0] TXN_RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [15:0] txn_count,
  output logic [1:0]  dbg_state
);

  // Handshake: req/wr/addr/wdata are sampled only at an edge where the FSM is IDLE;
  // the request is then owned by the responder until ready pulses for one cycle.
  // While busy is high, req is ignored and must be held or reissued afterwards.

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] txn_q;
  logic [7:0]  mem_q [DEPTH];

  logic          enter_from_idle;
  logic          enter_resp;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_wr;
  logic          acc_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;

  // With zero wait states the access happens on the accepting edge, so it must
  // use the live request rather than the latched copy.
  always_comb begin
    enter_from_idle = (state_q == S_IDLE) && req && (WAIT_CYCLES == 0);
    enter_resp      = enter_from_idle || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    acc_addr        = enter_from_idle ? addr  : addr_q;
    acc_wdata       = enter_from_idle ? wdata : wdata_q;
    acc_wr          = enter_from_idle ? wr    : wr_q;
    acc_err         = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(DEPTH));
    idx0            = acc_addr[AW-1:0];
    idx1            = idx0 + AW'(1);
    idx2            = idx0 + AW'(2);
    idx3            = idx0 + AW'(3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= TXN_RESET_VAL;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (enter_resp) begin
        state_q <= S_RESP;
        err_q   <= acc_err;
        if (acc_err || acc_wr) rdata_q <= '0;
        else rdata_q <= {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};
        if (!acc_err && acc_wr) begin
          mem_q[idx0] <= acc_wdata[31:24];
          mem_q[idx1] <= acc_wdata[23:16];
          mem_q[idx2] <= acc_wdata[15:8];
          mem_q[idx3] <= acc_wdata[7:0];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= wr;
            if (WAIT_CYCLES != 0) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          rdata_q <= '0;
          err_q   <= 1'b0;
          txn_q   <= txn_q + 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign txn_count = txn_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, random traffic against a
// byte-array reference memory, back-to-back/busy timing, zero-wait build and reset abort.
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int WC    = 2;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err, busy;
  logic [15:0] txn_count;
  logic [1:0]  dbg_state;

  logic        req0, wr0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        ready0, err0, busy0;
  logic [15:0] txn_count0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];
  int         ref_txn;
  logic [31:0] exp_q [$];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy),
    .txn_count(txn_count), .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .TXN_RESET_VAL(16'hFFFE)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0),
    .txn_count(txn_count0), .dbg_state(dbg_state0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model
  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH);
  endfunction

  function automatic logic [31:0] model_rdata(input logic w, input logic [31:0] a);
    if (w || model_err(a)) return 32'h0;
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
    if (w && !model_err(a)) begin
      ref_mem[a]   = d[31:24];
      ref_mem[a+1] = d[23:16];
      ref_mem[a+2] = d[15:8];
      ref_mem[a+3] = d[7:0];
    end
    ref_txn = (ref_txn + 1) % 65536;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_txn = 0;
  endtask

  // driver: one transaction on the main DUT, starting and ending at a negedge in IDLE
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input string nm);
    int n;
    logic busy_ok;
    logic [31:0] got_rd;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (!ready && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, WC + 1);
    chk({nm, "_busy_wait"}, {31'd0, busy_ok & busy}, 32'd1);
    got_rd = exp_q.pop_front();
    chk({nm, "_rdata"}, rdata, got_rd);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk({nm, "_ready_drop"}, {30'd0, ready, busy}, 32'd0);
    chk({nm, "_idle_outs"}, {rdata[30:0], err}, 32'd0);
    chk({nm, "_txn"}, {16'd0, txn_count}, 32'(ref_txn));
  endtask

  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input string nm);
    logic e;
    logic [31:0] r;
    e = model_err(a);
    r = model_rdata(w, a);
    model_apply(w, a, d);
    do_txn(w, a, d, e, r, nm);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vec [10];

  initial begin : main
    logic [31:0] bb_addr [12];
    logic [31:0] pat [3];
    int phase, acc, aidx;
    logic exp_busy, exp_ready;
    logic [31:0] exp_rd;

    vec[0] = '{1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0};
    vec[1] = '{1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678};
    vec[2] = '{1'b0, 32'h11, 32'h0,        1'b1, 32'h0};
    vec[3] = '{1'b1, 32'h20, 32'hAABBCCDD, 1'b0, 32'h0};
    vec[4] = '{1'b1, 32'h24, 32'h11223344, 1'b0, 32'h0};
    vec[5] = '{1'b0, 32'h20, 32'h0,        1'b0, 32'hAABBCCDD};
    vec[6] = '{1'b0, 32'h24, 32'h0,        1'b0, 32'h11223344};
    vec[7] = '{1'b1, 32'h80, 32'hCAFEF00D, 1'b1, 32'h0};
    vec[8] = '{1'b1, 32'h02, 32'h55555555, 1'b1, 32'h0};
    vec[9] = '{1'b0, 32'h7C, 32'h0,        1'b0, 32'h0};

    req = 0; wr = 0; addr = 0; wdata = 0;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    model_clear();

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_txn", {16'd0, txn_count}, 32'd0);
    chk("reset_outs", rdata | {31'd0, err}, 32'd0);
    chk("reset_txn0", {16'd0, txn_count0}, 32'h0000FFFE);
    model_txn(1'b0, 32'h0, 32'h0, "reset_read0");

    // directed table
    for (int i = 0; i < 10; i++) begin
      model_apply(vec[i].wr, vec[i].addr, vec[i].wdata);
      do_txn(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].exp_err, vec[i].exp_rdata,
             $sformatf("vec%0d", i));
    end
    chk("mem_20_msb", {24'd0, dut.mem_q[32'h20]}, 32'hAA);
    chk("mem_23_lsb", {24'd0, dut.mem_q[32'h23]}, 32'hDD);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      else a = 32'($urandom_range(0, 31) * 4);
      model_txn(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", i));
    end

    // back-to-back: req held for 12 cycles on both builds
    pat[0] = 32'h10; pat[1] = 32'h20; pat[2] = 32'h24;
    for (int n = 0; n < 12; n++) bb_addr[n] = pat[n % 3];
    @(negedge clk);
    for (int n = 0; n <= 13; n++) begin
      if (n > 0) @(negedge clk);
      // main build: period WC+2, first acceptance at edge 1
      phase = (n - 1) % (WC + 2);
      acc = n - phase;
      exp_busy  = (n >= 1) && (acc >= 1) && (acc <= 12) && (phase <= WC);
      exp_ready = exp_busy && (phase == WC);
      chk($sformatf("b2b_busy_n%0d", n), {31'd0, busy}, {31'd0, exp_busy});
      chk($sformatf("b2b_ready_n%0d", n), {31'd0, ready}, {31'd0, exp_ready});
      if (exp_ready) begin
        aidx = acc - 1;
        exp_rd = model_rdata(1'b0, bb_addr[aidx]);
        model_apply(1'b0, bb_addr[aidx], 32'h0);
        chk($sformatf("b2b_rdata_n%0d", n), rdata, exp_rd);
      end
      // zero-wait build: period 2, RESP right after each acceptance
      phase = (n - 1) % 2;
      acc = n - phase;
      exp_busy  = (n >= 1) && (acc >= 1) && (acc <= 12) && (phase == 0);
      chk($sformatf("b2b0_ready_n%0d", n), {30'd0, ready0, busy0}, {30'd0, exp_busy, exp_busy});
      if (exp_busy) chk($sformatf("b2b0_rdata_n%0d", n), {rdata0[30:0], err0}, 32'd0);
      if (n == 4) chk("wrap_txn0", {16'd0, txn_count0}, 32'd0);
      if (n < 12) begin
        req = 1'b1; wr = 1'b0; addr = bb_addr[n];
        req0 = 1'b1; wr0 = 1'b0; addr0 = bb_addr[n];
      end else begin
        req = 1'b0; req0 = 1'b0;
      end
    end
    chk("b2b_txn", {16'd0, txn_count}, 32'(ref_txn));
    chk("b2b0_txn", {16'd0, txn_count0}, 32'h4);

    // reset mid-write
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_outs", {30'd0, ready, busy}, 32'd0);
    chk("abort_txn", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("abort_noready_%0d", n), {31'd0, ready}, 32'd0);
    end
    chk("abort_txn_after", {16'd0, txn_count}, 32'd0);
    model_txn(1'b0, 32'h40, 32'h0, "abort_read40");
    model_txn(1'b0, 32'h10, 32'h0, "abort_read10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
